// File: rtl/decode_alu_stage_if.sv
// -----------------------------------------------------------------------------
// decode_alu_stage_if
// Handshake bundle for the decode_alu_stage pipeline stage.
//   Upstream side  : in_valid, in_ready, in_instr, in_pc
//   Downstream side: out_valid, out_ready, out_rs1/rs2/rd, out_alu_control,
//                    out_imm, out_is_imm, out_illegal, out_pc
// Modports:
//   master - the environment around the stage (drives in_* and out_ready)
//   slave  - the decode stage itself
// -----------------------------------------------------------------------------
interface decode_alu_stage_if #(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [XLEN-1:0]       in_pc;

  logic                  out_valid;
  logic                  out_ready;
  logic [4:0]            out_rs1;
  logic [4:0]            out_rs2;
  logic [4:0]            out_rd;
  logic [ALU_CTRL_W-1:0] out_alu_control;
  logic [XLEN-1:0]       out_imm;
  logic                  out_is_imm;
  logic                  out_illegal;
  logic [XLEN-1:0]       out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_rs1, out_rs2, out_rd, out_alu_control,
           out_imm, out_is_imm, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_rs1, out_rs2, out_rd, out_alu_control,
           out_imm, out_is_imm, out_illegal, out_pc
  );
endinterface

// File: rtl/decode_alu_stage.sv
// -----------------------------------------------------------------------------
// decode_alu_stage
// Registered decode stage for RV32/RV64 integer ALU instructions (OP and
// OP-IMM). Produces register indices, a 5-bit ALU code {m, f7b5, funct3}, a
// sign-extended I-immediate and an illegal-encoding flag. A main register
// plus a skid register give full throughput with a registered in_ready.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   flush  - synchronous flush; empties both entries, drops the offered input
//   bus    - decode_alu_stage_if.slave (upstream and downstream handshakes)
//
// Configuration macro:
//   DECODE_MEXT_EN - when defined, R-type funct7=0000001 decodes as the
//                    M-extension (alu_control = {1'b1, 1'b0, funct3}).
//                    When undefined those encodings are flagged illegal.
// -----------------------------------------------------------------------------
module decode_alu_stage #(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 5
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  decode_alu_stage_if.slave  bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef struct packed {
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [XLEN-1:0]       imm;
    logic                  is_imm;
    logic                  illegal;
    logic [XLEN-1:0]       pc;
  } entry_t;

  entry_t     dec;
  entry_t     main_q;
  entry_t     skid_q;
  logic       main_valid;
  logic       skid_valid;
  logic       in_fire;
  logic       main_free;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic [4:0] ctrl5;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];

  // ---------------------------------------------------------------------------
  // Combinational decode of the offered instruction
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave a value unassigned and infer a latch.
  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    ctrl5   = 5'b0;
    dec.rd  = bus.in_instr[11:7];
    dec.rs1 = bus.in_instr[19:15];
    dec.rs2 = bus.in_instr[24:20];
    dec.pc  = bus.in_pc;

    case (opcode)
      OPC_OP: begin
        case (funct7)
          7'b0000000: begin
            legal = 1'b1;
            ctrl5 = {2'b00, funct3};
          end
          // Only SUB and SRA use the alternate funct7.
          7'b0100000: begin
            if (funct3 == 3'b000 || funct3 == 3'b101) begin
              legal = 1'b1;
              ctrl5 = {2'b01, funct3};
            end
          end
`ifdef DECODE_MEXT_EN
          7'b0000001: begin
            legal = 1'b1;
            ctrl5 = {2'b10, funct3};
          end
`endif
          default: ;
        endcase
      end

      OPC_OP_IMM: begin
        // I-type has no rs2; imm[11:6] must be clean for shifts, except
        // that SRAI carries funct7 bit 5 (instr[30]).
        dec.rs2 = 5'd0;
        case (funct3)
          3'b001:  legal = (bus.in_instr[31:26] == 6'b000000);
          3'b101:  legal = (bus.in_instr[31:26] == 6'b000000) ||
                           (bus.in_instr[31:26] == 6'b010000);
          default: legal = 1'b1;
        endcase
        ctrl5 = {1'b0, (funct3 == 3'b101) & bus.in_instr[30], funct3};
        if (legal) begin
          dec.imm    = XLEN'(signed'(bus.in_instr[31:20]));
          dec.is_imm = 1'b1;
        end
      end

      default: ;
    endcase

    // Illegal encodings keep their register fields but carry no operation.
    if (legal) begin
      dec.alu_control = ALU_CTRL_W'(ctrl5);
    end
    dec.illegal = ~legal;
  end

  // ---------------------------------------------------------------------------
  // Main + skid buffer
  // ---------------------------------------------------------------------------
  // in_ready comes straight from a flop: the stage can always take one more
  // entry unless the skid register is occupied.
  assign in_fire   = bus.in_valid && !skid_valid;
  assign main_free = !main_valid || bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      // Skid never holds data while the input can fire (in_ready=0), so the
      // two cases below are exclusive and order is preserved.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_fire;
        if (in_fire) begin
          main_q <= dec;
        end
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: the skid payload is only read while skid_valid is set, so it is
  // left out of reset; the visible main payload is reset so outputs read 0.
  always_ff @(posedge clk) begin
    if (in_fire && !main_free) begin
      skid_q <= dec;
    end
  end

  assign bus.in_ready        = !skid_valid;
  assign bus.out_valid       = main_valid;
  assign bus.out_rs1         = main_q.rs1;
  assign bus.out_rs2         = main_q.rs2;
  assign bus.out_rd          = main_q.rd;
  assign bus.out_alu_control = main_q.alu_control;
  assign bus.out_imm         = main_q.imm;
  assign bus.out_is_imm      = main_q.is_imm;
  assign bus.out_illegal     = main_q.illegal;
  assign bus.out_pc          = main_q.pc;

endmodule

// File: tb/tb_decode_alu_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_alu_stage
// Self-checking bench for decode_alu_stage (XLEN=32, ALU_CTRL_W=5).
// A table of hand-decoded instructions, directed burst/stall, flush and
// mid-stall reset sequences, then randomized traffic against a queue-based
// reference model of the decoder and its two-entry buffer.
// -----------------------------------------------------------------------------
module tb_decode_alu_stage;

`ifdef DECODE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  ctrl;
    logic [31:0] imm;
    logic        is_imm;
    logic        illegal;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [14:0] regs;   // {rs1, rs2, rd}
    logic [4:0]  ctrl;
    logic [31:0] imm;
    logic        is_imm;
    logic        illegal;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  decode_alu_stage_if #(.XLEN(32), .ALU_CTRL_W(5)) bus ();

  decode_alu_stage #(.XLEN(32), .ALU_CTRL_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t held;
  exp_t last_out;
  bit   hold_pending = 1'b0;
  int   popped = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t s;
    s.rs1     = bus.out_rs1;
    s.rs2     = bus.out_rs2;
    s.rd      = bus.out_rd;
    s.ctrl    = bus.out_alu_control;
    s.imm     = bus.out_imm;
    s.is_imm  = bus.out_is_imm;
    s.illegal = bus.out_illegal;
    s.pc      = bus.out_pc;
    return s;
  endfunction

  // Reference decoder: recognise each supported mnemonic's encoding directly.
  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
    exp_t       e;
    bit         ok;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [5:0] hi;
    e    = '0;
    ok   = 1'b0;
    f7   = i[31:25];
    f3   = i[14:12];
    hi   = i[31:26];
    e.rd = i[11:7];
    e.rs1 = i[19:15];
    e.pc = pc;
    e.rs2 = (i[6:0] == 7'h13) ? 5'd0 : i[24:20];
    if (i[6:0] == 7'h33) begin
      if (f7 == 7'h00) begin ok = 1'b1; e.ctrl = {2'b00, f3}; end
      else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin ok = 1'b1; e.ctrl = {2'b01, f3}; end
      else if (f7 == 7'h01 && MEXT) begin ok = 1'b1; e.ctrl = {2'b10, f3}; end
    end else if (i[6:0] == 7'h13) begin
      if (f3 == 3'd1) begin ok = (hi == 6'd0); e.ctrl = 5'b00001; end
      else if (f3 == 3'd5 && hi == 6'd0) begin ok = 1'b1; e.ctrl = 5'b00101; end
      else if (f3 == 3'd5 && hi == 6'b010000) begin ok = 1'b1; e.ctrl = 5'b01101; end
      else if (f3 != 3'd5) begin ok = 1'b1; e.ctrl = {2'b00, f3}; end
      if (ok) begin
        e.imm    = {{20{i[31]}}, i[31:20]};
        e.is_imm = 1'b1;
      end
    end
    if (!ok) e.ctrl = 5'd0;
    e.illegal = !ok;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    logic [6:0]  f7;
    int          s;
    r = $urandom;
    s = $urandom_range(0, 9);
    op = (s < 4) ? 7'h33 : (s < 8) ? 7'h13 : r[6:0];
    case ($urandom_range(0, 5))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      3:       f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], op};
  endfunction

  // One clock of traffic, evaluated at the falling edge. The model tracks the
  // in-flight entries as a queue; occupancy alone determines the handshake.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic ordy, input logic fl, output bit fired);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = p;
    bus.out_ready = ordy;
    flush         = fl;
    fired         = 1'b0;
    check("out_valid", bus.out_valid, q.size() != 0);
    check("in_ready", bus.in_ready, q.size() < 2);
    if (hold_pending) check("hold_stable", snapshot(), held);
    hold_pending = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      if (bus.out_valid && ordy) begin
        if (q.size() == 0) begin
          check("unexpected_out", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          last_out = snapshot();
          check("entry", last_out, e);
          popped++;
        end
      end else if (bus.out_valid) begin
        hold_pending = 1'b1;
        held = snapshot();
      end
      if (v && bus.in_ready) begin
        q.push_back(ref_decode(ins, p));
        fired = 1'b1;
      end
    end
  endtask

  vec_t        vecs[9];
  logic [31:0] burst[8];
  bit          f;
  bit          saw_stall;
  int          sent;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{32'h40208033, {5'd1, 5'd2, 5'd0}, 5'b01000, 32'h0,        1'b0, 1'b0};
    vecs[1] = '{32'hFFF30293, {5'd6, 5'd0, 5'd5}, 5'b00000, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h02208033, {5'd1, 5'd2, 5'd0}, MEXT ? 5'b10000 : 5'b0, 32'h0, 1'b0, !MEXT};
    vecs[3] = '{32'h4030D093, {5'd1, 5'd0, 5'd1}, 5'b01101, 32'h403,      1'b1, 1'b0};
    vecs[4] = '{32'h04119113, {5'd3, 5'd0, 5'd2}, 5'b00000, 32'h0,        1'b0, 1'b1};
    vecs[5] = '{32'h005241B3, {5'd4, 5'd5, 5'd3}, 5'b00100, 32'h0,        1'b0, 1'b0};
    vecs[6] = '{32'h123450B7, {5'd8, 5'd3, 5'd1}, 5'b00000, 32'h0,        1'b0, 1'b1};
    vecs[7] = '{32'h40209033, {5'd1, 5'd2, 5'd0}, 5'b00000, 32'h0,        1'b0, 1'b1};
    vecs[8] = '{32'h80043393, {5'd8, 5'd0, 5'd7}, 5'b00011, 32'hFFFFF800, 1'b1, 1'b0};

    // Reset state
    #12;
    check("reset_payload", snapshot(), '0);
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_out_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-decoded table, one instruction at a time
    for (int k = 0; k < 9; k++) begin
      step(1'b1, vecs[k].instr, 32'h1000 + 32'(k * 4), 1'b1, 1'b0, f);
      step(1'b0, '0, '0, 1'b1, 1'b0, f);
      check("tbl_regs", {last_out.rs1, last_out.rs2, last_out.rd}, vecs[k].regs);
      check("tbl_ctrl", last_out.ctrl, vecs[k].ctrl);
      check("tbl_imm", last_out.imm, vecs[k].imm);
      check("tbl_flags", {last_out.is_imm, last_out.illegal}, {vecs[k].is_imm, vecs[k].illegal});
    end

    // Burst of 8 with a 3-cycle downstream stall in the middle
    for (int k = 0; k < 8; k++) burst[k] = rand_instr();
    popped = 0;
    sent = 0;
    saw_stall = 1'b0;
    for (int c = 0; c < 40 && (sent < 8 || q.size() != 0); c++) begin
      if (sent < 8 && !bus.in_ready) saw_stall = 1'b1;
      step(sent < 8, (sent < 8) ? burst[sent] : 32'h0, 32'h2000 + 32'(sent * 4),
           !(c >= 3 && c < 6), 1'b0, f);
      if (f) sent++;
    end
    check("burst_in_ready_dropped", saw_stall, 1'b1);
    check("burst_count", popped, 8);

    // Flush with both entries full and an input offered
    step(1'b1, 32'h00208033, 32'h3000, 1'b0, 1'b0, f);
    step(1'b1, 32'h00308033, 32'h3004, 1'b0, 1'b0, f);
    step(1'b1, 32'h00408033, 32'h3008, 1'b1, 1'b1, f);
    step(1'b0, '0, '0, 1'b1, 1'b0, f);
    step(1'b0, '0, '0, 1'b1, 1'b0, f);
    // Flush with one entry and in_ready high: offered input is discarded
    step(1'b1, 32'h00508033, 32'h300C, 1'b0, 1'b0, f);
    step(1'b1, 32'h00608033, 32'h3010, 1'b1, 1'b1, f);
    step(1'b0, '0, '0, 1'b1, 1'b0, f);
    step(1'b0, '0, '0, 1'b1, 1'b0, f);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0, f);
    end
    for (int c = 0; c < 20 && q.size() != 0; c++) step(1'b0, '0, '0, 1'b1, 1'b0, f);
    check("drain_done", q.size(), 0);

    // Reset in the middle of a stall with both entries full
    step(1'b1, 32'h00708033, 32'h4000, 1'b0, 1'b0, f);
    step(1'b1, 32'h00808033, 32'h4004, 1'b0, 1'b0, f);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("midreset_payload", snapshot(), '0);
    check("midreset_out_valid", bus.out_valid, 1'b0);
    check("midreset_in_ready", bus.in_ready, 1'b1);
    q.delete();
    hold_pending = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) step(1'b0, '0, '0, 1'b1, 1'b0, f);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
